// File: rtl/riscv_dift_policy_csr.sv
// DIFT policy CSR block: shadowed TPR/TCR with atomic commit on pipeline idle, plus TVPC/TVS violation capture.
// Optional feature macro: DIFT_POLICY_LOCK_EN (TCR[31] lock bit freezes TPR/TCR until reset).
module riscv_dift_policy_csr #(
    parameter logic [11:0] CSR_BASE  = 12'h7D0,
    parameter logic [31:0] TPR_RESET = 32'h0000_0000,
    parameter logic [31:0] TCR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_access_i,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_hit_o,
    input  logic        pipe_idle_i,
    output logic        commit_pending_o,
    output logic [31:0] tpr_o,
    output logic [31:0] tcr_o,
    input  logic        tag_violation_i,
    input  logic [31:0] violation_pc_i,
    input  logic [4:0]  violation_cls_i,
    output logic        tag_exc_o
);
    localparam logic [1:0] CSR_OP_NONE  = 2'd0;
    localparam logic [1:0] CSR_OP_WRITE = 2'd1;
    localparam logic [1:0] CSR_OP_SET   = 2'd2;
    localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

    localparam logic [11:0] ADDR_TPR  = CSR_BASE;
    localparam logic [11:0] ADDR_TCR  = CSR_BASE + 12'd1;
    localparam logic [11:0] ADDR_TVPC = CSR_BASE + 12'd2;
    localparam logic [11:0] ADDR_TVS  = CSR_BASE + 12'd3;

    localparam logic [31:0] TPR_MASK = 32'h0003_BFFF;
`ifdef DIFT_POLICY_LOCK_EN
    localparam logic [31:0] TCR_MASK = 32'h80FF_FFFF;
`else
    localparam logic [31:0] TCR_MASK = 32'h00FF_FFFF;
`endif

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state_reg, state_next;
    logic [31:0] tpr_shadow_reg, tpr_shadow_next;
    logic [31:0] tcr_shadow_reg, tcr_shadow_next;
    logic [31:0] tpr_active_reg, tcr_active_reg;
    logic [31:0] tvpc_reg, tvpc_next;
    logic        tvs_valid_reg, tvs_valid_next;
    logic        tvs_ovf_reg, tvs_ovf_next;
    logic [4:0]  tvs_cls_reg, tvs_cls_next;
    logic        tag_exc_reg;

    logic        is_tpr, is_tcr, is_tvpc, is_tvs;
    logic        csr_write, locked;
    logic        wr_tpr, wr_tcr, wr_tvs;
    logic        commit;
    logic [31:0] tvs_read;

    function automatic logic [31:0] csr_update(input logic [31:0] q, input logic [31:0] w,
                                               input logic [1:0] op);
        case (op)
            CSR_OP_WRITE: csr_update = w;
            CSR_OP_SET:   csr_update = q | w;
            CSR_OP_CLEAR: csr_update = q & ~w;
            default:      csr_update = q;
        endcase
    endfunction

    assign is_tpr  = (csr_addr_i == ADDR_TPR);
    assign is_tcr  = (csr_addr_i == ADDR_TCR);
    assign is_tvpc = (csr_addr_i == ADDR_TVPC);
    assign is_tvs  = (csr_addr_i == ADDR_TVS);

    assign csr_hit_o = csr_access_i & (is_tpr | is_tcr | is_tvpc | is_tvs);
    assign csr_write = csr_hit_o & (csr_op_i != CSR_OP_NONE);

`ifdef DIFT_POLICY_LOCK_EN
    assign locked = tcr_active_reg[31];
`else
    assign locked = 1'b0;
`endif

    assign wr_tpr = csr_write & is_tpr & ~locked;
    assign wr_tcr = csr_write & is_tcr & ~locked;
    assign wr_tvs = csr_write & is_tvs;

    // The class field is only meaningful while a capture is valid, so it reads as zero otherwise.
    assign tvs_read = {25'd0, tvs_cls_reg & {5{tvs_valid_reg}}, tvs_ovf_reg, tvs_valid_reg};

    always_comb begin
        csr_rdata_o = 32'd0;
        if (is_tpr)       csr_rdata_o = tpr_shadow_reg;
        else if (is_tcr)  csr_rdata_o = tcr_shadow_reg;
        else if (is_tvpc) csr_rdata_o = tvpc_reg;
        else if (is_tvs)  csr_rdata_o = tvs_read;
    end

    always_comb begin
        tpr_shadow_next = tpr_shadow_reg;
        tcr_shadow_next = tcr_shadow_reg;
        if (wr_tpr) tpr_shadow_next = csr_update(tpr_shadow_reg, csr_wdata_i, csr_op_i) & TPR_MASK;
        if (wr_tcr) tcr_shadow_next = csr_update(tcr_shadow_reg, csr_wdata_i, csr_op_i) & TCR_MASK;
    end

    // A write seen in IDLE always spends at least one cycle in PEND before committing.
    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: if (wr_tpr | wr_tcr) state_next = PEND;
            PEND: if (pipe_idle_i) begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A violation always takes priority over a same-cycle software write to TVS.
    always_comb begin
        tvpc_next      = tvpc_reg;
        tvs_valid_next = tvs_valid_reg;
        tvs_ovf_next   = tvs_ovf_reg;
        tvs_cls_next   = tvs_cls_reg;
        if (tag_violation_i) begin
            if (!tvs_valid_reg) begin
                tvpc_next      = violation_pc_i;
                tvs_cls_next   = violation_cls_i;
                tvs_valid_next = 1'b1;
                tvs_ovf_next   = 1'b0;
            end else begin
                tvs_ovf_next = 1'b1;
            end
        end else if (wr_tvs) begin
            {tvs_ovf_next, tvs_valid_next} = 2'(csr_update(tvs_read, csr_wdata_i, csr_op_i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            tpr_shadow_reg <= TPR_RESET;
            tcr_shadow_reg <= TCR_RESET;
            tpr_active_reg <= TPR_RESET;
            tcr_active_reg <= TCR_RESET;
            tvpc_reg       <= 32'd0;
            tvs_valid_reg  <= 1'b0;
            tvs_ovf_reg    <= 1'b0;
            tvs_cls_reg    <= 5'd0;
            tag_exc_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tpr_shadow_reg <= tpr_shadow_next;
            tcr_shadow_reg <= tcr_shadow_next;
            if (commit) begin
                tpr_active_reg <= tpr_shadow_next;
                tcr_active_reg <= tcr_shadow_next;
            end
            tvpc_reg      <= tvpc_next;
            tvs_valid_reg <= tvs_valid_next;
            tvs_ovf_reg   <= tvs_ovf_next;
            tvs_cls_reg   <= tvs_cls_next;
            tag_exc_reg   <= tag_violation_i & ~tvs_valid_reg;
        end
    end

    assign commit_pending_o = (state_reg == PEND);
    assign tpr_o            = tpr_active_reg;
    assign tcr_o            = tcr_active_reg;
    assign tag_exc_o        = tag_exc_reg;
endmodule

// File: tb/tb_riscv_dift_policy_csr.sv
// Directed bench for riscv_dift_policy_csr: shadow/commit handshake, violation capture and optional lock.
module tb_riscv_dift_policy_csr;
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [11:0] A_TPR  = 12'h7D0;
    localparam logic [11:0] A_TCR  = 12'h7D1;
    localparam logic [11:0] A_TVPC = 12'h7D2;
    localparam logic [11:0] A_TVS  = 12'h7D3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_access_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic        pipe_idle_i;
    logic        commit_pending_o;
    logic [31:0] tpr_o;
    logic [31:0] tcr_o;
    logic        tag_violation_i;
    logic [31:0] violation_pc_i;
    logic [4:0]  violation_cls_i;
    logic        tag_exc_o;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_dift_policy_csr dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_access_i     (csr_access_i),
        .csr_addr_i       (csr_addr_i),
        .csr_op_i         (csr_op_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_rdata_o      (csr_rdata_o),
        .csr_hit_o        (csr_hit_o),
        .pipe_idle_i      (pipe_idle_i),
        .commit_pending_o (commit_pending_o),
        .tpr_o            (tpr_o),
        .tcr_o            (tcr_o),
        .tag_violation_i  (tag_violation_i),
        .violation_pc_i   (violation_pc_i),
        .violation_cls_i  (violation_cls_i),
        .tag_exc_o        (tag_exc_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata);
        csr_access_i = 1'b1;
        csr_addr_i   = addr;
        csr_op_i     = op;
        csr_wdata_i  = wdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        csr_op_i        = OP_NONE;
        tag_violation_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(A_TVS, OP_NONE, 32'd0);
        n_checks++; if (tpr_o !== 32'd0) begin n_fail++; $display("FAIL reset_tpr: got %h want %h", tpr_o, 32'd0); end
        n_checks++; if (tcr_o !== 32'd0) begin n_fail++; $display("FAIL reset_tcr: got %h want %h", tcr_o, 32'd0); end
        n_checks++; if (commit_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", commit_pending_o); end
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_tvs: got %h want %h", csr_rdata_o, 32'd0); end
        n_checks++; if (tag_exc_o !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b want 0", tag_exc_o); end
        rst_n = 1'b1;
        $display("reset: tpr=%h tcr=%h pending=%b", tpr_o, tcr_o, commit_pending_o);
    endtask

    task automatic test_tpr_commit();
        pipe_idle_i = 1'b0;
        drive(A_TPR, OP_WRITE, 32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (csr_rdata_o !== 32'h0003_BFFF) begin n_fail++; $display("FAIL tpr_shadow_rd: got %h want %h", csr_rdata_o, 32'h0003_BFFF); end
            n_checks++; if (tpr_o !== 32'd0) begin n_fail++; $display("FAIL tpr_held: cycle %0d got %h want %h", i, tpr_o, 32'd0); end
            n_checks++; if (commit_pending_o !== 1'b1) begin n_fail++; $display("FAIL tpr_pending: got %b want 1", commit_pending_o); end
            if (i < 2) tick();
        end
        pipe_idle_i = 1'b1;
        tick();
        n_checks++; if (tpr_o !== 32'h0003_BFFF) begin n_fail++; $display("FAIL tpr_commit: got %h want %h", tpr_o, 32'h0003_BFFF); end
        n_checks++; if (commit_pending_o !== 1'b0) begin n_fail++; $display("FAIL tpr_pending_fall: got %b want 0", commit_pending_o); end
        pipe_idle_i = 1'b0;
        $display("tpr write/commit: tpr_o=%h pending=%b", tpr_o, commit_pending_o);
    endtask

    task automatic test_tcr_set_clear();
        logic [31:0] wval, wexp;
        drive(A_TCR, OP_SET, 32'h1);
        tick();
        n_checks++; if (csr_rdata_o !== 32'h1) begin n_fail++; $display("FAIL tcr_set_rd: got %h want %h", csr_rdata_o, 32'h1); end
        n_checks++; if (tcr_o !== 32'd0) begin n_fail++; $display("FAIL tcr_set_held: got %h want %h", tcr_o, 32'd0); end
        pipe_idle_i = 1'b1;
        drive(A_TCR, OP_CLEAR, 32'h1);
        tick();
        n_checks++; if (tcr_o !== 32'd0) begin n_fail++; $display("FAIL tcr_clear_commit: got %h want %h", tcr_o, 32'd0); end
        n_checks++; if (commit_pending_o !== 1'b0) begin n_fail++; $display("FAIL tcr_clear_pending: got %b want 0", commit_pending_o); end
        n_checks++; if (tpr_o !== 32'h0003_BFFF) begin n_fail++; $display("FAIL tcr_tpr_kept: got %h want %h", tpr_o, 32'h0003_BFFF); end
        $display("tcr set then clear at commit: tcr_o=%h", tcr_o);
`ifdef DIFT_POLICY_LOCK_EN
        wval = 32'h7FFF_FFFF;
`else
        wval = 32'hFFFF_FFFF;
`endif
        wexp = 32'h00FF_FFFF;
        drive(A_TCR, OP_WRITE, wval);
        tick();
        n_checks++; if (commit_pending_o !== 1'b1) begin n_fail++; $display("FAIL tcr_min_latency_pend: got %b want 1", commit_pending_o); end
        n_checks++; if (tcr_o !== 32'd0) begin n_fail++; $display("FAIL tcr_min_latency_held: got %h want %h", tcr_o, 32'd0); end
        tick();
        n_checks++; if (tcr_o !== wexp) begin n_fail++; $display("FAIL tcr_mask_commit: got %h want %h", tcr_o, wexp); end
        n_checks++; if (commit_pending_o !== 1'b0) begin n_fail++; $display("FAIL tcr_mask_pending: got %b want 0", commit_pending_o); end
        pipe_idle_i = 1'b0;
        $display("tcr write with idle pipe: tcr_o=%h", tcr_o);
    endtask

    task automatic test_unmapped();
        drive(12'h7D4, OP_NONE, 32'd0);
        n_checks++; if (csr_hit_o !== 1'b0) begin n_fail++; $display("FAIL unmapped_hit: got %b want 0", csr_hit_o); end
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL unmapped_rdata: got %h want %h", csr_rdata_o, 32'd0); end
        drive(12'h7CF, OP_NONE, 32'd0);
        n_checks++; if (csr_hit_o !== 1'b0) begin n_fail++; $display("FAIL unmapped_low_hit: got %b want 0", csr_hit_o); end
        drive(A_TVS, OP_NONE, 32'd0);
        n_checks++; if (csr_hit_o !== 1'b1) begin n_fail++; $display("FAIL mapped_hit: got %b want 1", csr_hit_o); end
        $display("unmapped address decode checked");
    endtask

    task automatic test_violation();
        drive(A_TVS, OP_NONE, 32'd0);
        tag_violation_i = 1'b1; violation_pc_i = 32'h100; violation_cls_i = 5'd5;
        tick();
        n_checks++; if (tag_exc_o !== 1'b1) begin n_fail++; $display("FAIL viol_exc: got %b want 1", tag_exc_o); end
        n_checks++; if (csr_rdata_o !== 32'h15) begin n_fail++; $display("FAIL viol_tvs: got %h want %h", csr_rdata_o, 32'h15); end
        drive(A_TVPC, OP_NONE, 32'd0);
        n_checks++; if (csr_rdata_o !== 32'h100) begin n_fail++; $display("FAIL viol_tvpc: got %h want %h", csr_rdata_o, 32'h100); end
        tag_violation_i = 1'b1; violation_pc_i = 32'h200; violation_cls_i = 5'd9;
        tick();
        n_checks++; if (tag_exc_o !== 1'b0) begin n_fail++; $display("FAIL viol2_no_pulse: got %b want 0", tag_exc_o); end
        n_checks++; if (csr_rdata_o !== 32'h100) begin n_fail++; $display("FAIL viol2_tvpc: got %h want %h", csr_rdata_o, 32'h100); end
        drive(A_TVS, OP_NONE, 32'd0);
        n_checks++; if (csr_rdata_o !== 32'h17) begin n_fail++; $display("FAIL viol2_tvs: got %h want %h", csr_rdata_o, 32'h17); end
        tick();
        n_checks++; if (tag_exc_o !== 1'b0) begin n_fail++; $display("FAIL viol2_still_low: got %b want 0", tag_exc_o); end
        drive(A_TVPC, OP_WRITE, 32'hDEAD_BEEF);
        n_checks++; if (csr_hit_o !== 1'b1) begin n_fail++; $display("FAIL tvpc_wr_hit: got %b want 1", csr_hit_o); end
        tick();
        n_checks++; if (csr_rdata_o !== 32'h100) begin n_fail++; $display("FAIL tvpc_readonly: got %h want %h", csr_rdata_o, 32'h100); end
        drive(A_TVS, OP_CLEAR, 32'h3);
        tick();
        n_checks++; if (csr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL tvs_clear: got %h want %h", csr_rdata_o, 32'h0); end
        $display("violation capture/overflow/clear: tvs=%h", csr_rdata_o);
    endtask

    task automatic test_violation_vs_write();
        drive(A_TVS, OP_CLEAR, 32'h3);
        tag_violation_i = 1'b1; violation_pc_i = 32'h300; violation_cls_i = 5'd23;
        tick();
        n_checks++; if (csr_rdata_o !== 32'h5D) begin n_fail++; $display("FAIL coinc_tvs: got %h want %h", csr_rdata_o, 32'h5D); end
        n_checks++; if (tag_exc_o !== 1'b1) begin n_fail++; $display("FAIL coinc_exc: got %b want 1", tag_exc_o); end
        drive(A_TVPC, OP_NONE, 32'd0);
        n_checks++; if (csr_rdata_o !== 32'h300) begin n_fail++; $display("FAIL coinc_tvpc: got %h want %h", csr_rdata_o, 32'h300); end
        $display("violation vs TVS clear same cycle: tvpc=%h", csr_rdata_o);
    endtask

    task automatic test_reset_mid_pend();
        pipe_idle_i = 1'b0;
        drive(A_TPR, OP_WRITE, 32'h0000_1234);
        tick();
        n_checks++; if (commit_pending_o !== 1'b1) begin n_fail++; $display("FAIL midpend_pending: got %b want 1", commit_pending_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL midpend_shadow: got %h want %h", csr_rdata_o, 32'd0); end
        n_checks++; if (tpr_o !== 32'd0) begin n_fail++; $display("FAIL midpend_tpr: got %h want %h", tpr_o, 32'd0); end
        n_checks++; if (commit_pending_o !== 1'b0) begin n_fail++; $display("FAIL midpend_pending_clr: got %b want 0", commit_pending_o); end
        drive(A_TVS, OP_NONE, 32'd0);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL midpend_tvs: got %h want %h", csr_rdata_o, 32'd0); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (tpr_o !== 32'd0) begin n_fail++; $display("FAIL midpend_no_commit: got %h want %h", tpr_o, 32'd0); end
        $display("reset during PEND: tpr_o=%h pending=%b", tpr_o, commit_pending_o);
    endtask

`ifdef DIFT_POLICY_LOCK_EN
    task automatic test_lock();
        pipe_idle_i = 1'b1;
        drive(A_TCR, OP_WRITE, 32'h8000_0001);
        tick();
        tick();
        n_checks++; if (tcr_o !== 32'h8000_0001) begin n_fail++; $display("FAIL lock_commit: got %h want %h", tcr_o, 32'h8000_0001); end
        drive(A_TCR, OP_WRITE, 32'h0);
        n_checks++; if (csr_hit_o !== 1'b1) begin n_fail++; $display("FAIL lock_hit: got %b want 1", csr_hit_o); end
        tick();
        n_checks++; if (commit_pending_o !== 1'b0) begin n_fail++; $display("FAIL lock_no_pend: got %b want 0", commit_pending_o); end
        tick();
        n_checks++; if (tcr_o !== 32'h8000_0001) begin n_fail++; $display("FAIL lock_tcr_held: got %h want %h", tcr_o, 32'h8000_0001); end
        n_checks++; if (csr_rdata_o !== 32'h8000_0001) begin n_fail++; $display("FAIL lock_shadow: got %h want %h", csr_rdata_o, 32'h8000_0001); end
        drive(A_TVS, OP_WRITE, 32'h2);
        tick();
        n_checks++; if (csr_rdata_o !== 32'h2) begin n_fail++; $display("FAIL lock_tvs_writable: got %h want %h", csr_rdata_o, 32'h2); end
        pipe_idle_i = 1'b0;
        $display("lock: tcr_o=%h pending=%b", tcr_o, commit_pending_o);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        csr_access_i = 1'b0; csr_addr_i = 12'd0; csr_op_i = OP_NONE; csr_wdata_i = 32'd0;
        pipe_idle_i = 1'b0;
        tag_violation_i = 1'b0; violation_pc_i = 32'd0; violation_cls_i = 5'd0;
        test_reset();
        test_tpr_commit();
        test_tcr_set_clear();
        test_unmapped();
        test_violation();
        test_violation_vs_write();
        test_reset_mid_pend();
`ifdef DIFT_POLICY_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
